tpg: RTL
========

Name: tpg

Overview:
- Traffic pattern generator (TPG) for NoC bring-up benches.
- Injects a stream of sequenced packets into a router port through a valid/ready interface, at a programmable rate.
- Sits directly upstream of the traffic sink. Packet header layout is identical to what the sink decodes.
- Asserts done once its packet budget has been transferred.

Parameters:
- WIDTH, 32: packet width.
- N, 16: number of NoC nodes; must be a power of two and ≥2.
- N_ADDR_WIDTH, $clog2(N): router address width.
- ID, 8'd0: unique generator id, placed in every packet.
- NODE, 0: router index this TPG drives (source address).
- DEST, 15: destination address when DEST_MODE=0.
- DEST_MODE, 0: 0 = fixed DEST; 1 = round-robin over all nodes except NODE.
- INTERVAL, 4: minimum cycles from one handshake to the next valid assertion; ≥1.
- NUM_PKTS, 1002: total packets to send; must be ≤ 2^CW, where CW = WIDTH-2*N_ADDR_WIDTH-8.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: permits injection.
- done, output, 1: all NUM_PKTS transferred.
- data_out, output, WIDTH: packet.
- valid_out, output, 1: data_out holds a packet.
- ready_in, input, 1: downstream accepts.

Behaviour:
- Packet fields, MSB to LSB:
  - [WIDTH-1 -: A] = NODE (src)
  - next A bits = dst
  - next 8 bits = ID
  - [CW-1:0] = seq
  - A = N_ADDR_WIDTH.
- Reset (rst=0, asynchronous, no clock needed):
  - valid_out=0, done=0, data_out=0, seq=0, gap counter=0, state IDLE.
  - dst = DEST (mode 0) or (NODE+1) mod N (mode 1).
- Handshake:
  - Transfer occurs on a rising edge where valid_out && ready_in.
  - While valid_out=1 and no transfer, data_out and valid_out stay stable.
  - valid_out never drops without a transfer, except on reset.
- FSM:
  - IDLE: on an edge with enable=1 → SEND. valid_out=1 and the packet is presented from the next cycle.
  - SEND: on transfer:
    - seq += 1; dst advances (mode 1).
    - If seq was NUM_PKTS-1 → DONE.
    - Else if INTERVAL=1 → stay in SEND, next packet presented the following cycle (back-to-back).
    - Else → WAIT with gap counter loaded to INTERVAL-1 and valid_out=0.
    - enable is ignored while in SEND.
  - WAIT: gap counter decrements only on edges with enable=1. When it reaches 0 on an edge → SEND. Next valid therefore rises exactly INTERVAL cycles after the previous handshake when enable stays high.
  - DONE: valid_out=0, done=1 (registered; high the cycle after the final transfer). Held until reset.
- Round-robin: next = (dst+1) mod N. If that equals NODE, use (NODE+1) mod N. Wrap uses natural A-bit overflow.
- seq never wraps, because NUM_PKTS ≤ 2^CW.
- Reset mid-operation: all state is discarded. A packet that was valid but not yet transferred is lost. Restart begins at seq 0.

Test Plan:
- Defaults (NODE=0, DEST=15, ID=0), enable=1, ready_in=1 -> first data_out=0x0F000000. Second packet 0x0F000001 has valid rising exactly 4 cycles after the first handshake. Seq increments by 1 per packet.
- ready_in=0 for 5 cycles while valid_out=1 -> data_out held at the same value and valid held 1. Seq does not advance; transfer occurs on the first edge with ready_in=1.
- DEST_MODE=1, NODE=3 -> dst sequence 4,5,…,15,0,1,2,4. Value 3 never appears.
- NUM_PKTS=3, INTERVAL=1, ready_in=1 -> exactly 3 transfers on consecutive edges (seq 0,1,2). done=1 on the cycle after the third; valid_out stays 0 afterwards.
- Assert rst=0 asynchronously mid-SEND -> valid_out falls immediately without a clock edge. After release with enable=1, first packet again has seq=0.
- enable=0 during WAIT for 10 cycles -> no valid; gap resumes on re-enable. enable=0 while in SEND -> valid_out held until transfer.

Source files
------------

// File: rtl/tpg.sv
// ---------------------------------------------------------------------------
// tpg -- traffic pattern generator for NoC bring-up.
// Sends NUM_PKTS sequenced packets into a router port over valid/ready.
// After each handshake it waits a programmable number of enabled cycles
// before offering the next packet. done goes high once the whole budget
// has been transferred.
//
// Packet layout, MSB to LSB: {src=NODE, dst, ID[7:0], seq[CW-1:0]}
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active low
//   enable     permits injection (ignored while a packet is offered)
//   done       registered; high once all NUM_PKTS have been transferred
//   data_out   packet, held stable while valid_out && !ready_in
//   valid_out  data_out holds a packet
//   ready_in   downstream accepts
// ---------------------------------------------------------------------------
module tpg #(
   parameter int         WIDTH        = 32,
   parameter int         N            = 16,
   parameter int         N_ADDR_WIDTH = $clog2(N),
   parameter logic [7:0] ID           = 8'd0,
   parameter int         NODE         = 0,
   parameter int         DEST         = 15,
   parameter int         DEST_MODE    = 0,
   parameter int         INTERVAL     = 4,
   parameter int         NUM_PKTS     = 1002
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic             done,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   input  logic             ready_in
);

   localparam int A  = N_ADDR_WIDTH;
   localparam int CW = WIDTH - 2*A - 8;
   // gap counter only has to hold INTERVAL-1
   localparam int GW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

   localparam logic [A-1:0]  SRC    = A'(NODE);
   localparam logic [A-1:0]  DST0   = (DEST_MODE != 0) ? A'(NODE + 1) : A'(DEST);
   localparam logic [CW-1:0] LAST   = CW'(NUM_PKTS - 1);
   localparam logic [GW-1:0] GAP_LD = GW'(INTERVAL - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t        state;
   logic [CW-1:0] seq;
   logic [A-1:0]  dst;
   logic [GW-1:0] gap;

   logic [CW-1:0] seq_nxt;
   logic [A-1:0]  dst_nxt;

   // Round-robin skips our own node; the +1 wraps naturally at A bits.
   function automatic logic [A-1:0] next_dst(input logic [A-1:0] d);
      logic [A-1:0] n;
      n = d + A'(1);
      if (n == SRC) n = SRC + A'(1);
      return (DEST_MODE != 0) ? n : d;
   endfunction

   function automatic logic [WIDTH-1:0] pkt(input logic [A-1:0] d,
                                            input logic [CW-1:0] s);
      return {SRC, d, ID, s};
   endfunction

   assign seq_nxt = seq + CW'(1);
   assign dst_nxt = next_dst(dst);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         seq       <= '0;
         dst       <= DST0;
         gap       <= '0;
         valid_out <= 1'b0;
         done      <= 1'b0;
         data_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state     <= SEND;
                  valid_out <= 1'b1;
                  data_out  <= pkt(dst, seq);
               end
            end
            SEND: begin
               // Offer is held until accepted; enable has no say here.
               if (ready_in) begin
                  seq <= seq_nxt;
                  dst <= dst_nxt;
                  if (seq == LAST) begin
                     state     <= DONE;
                     valid_out <= 1'b0;
                     done      <= 1'b1;
                  end else if (INTERVAL == 1) begin
                     data_out <= pkt(dst_nxt, seq_nxt);
                  end else begin
                     state     <= WAIT;
                     valid_out <= 1'b0;
                     gap       <= GAP_LD;
                  end
               end
            end
            WAIT: begin
               // Leave on the edge the counter would reach zero, so valid
               // rises INTERVAL-1 enabled edges after the handshake edge.
               if (enable) begin
                  if (gap == GW'(1)) begin
                     gap       <= '0;
                     state     <= SEND;
                     valid_out <= 1'b1;
                     data_out  <= pkt(dst, seq);
                  end else begin
                     gap <= gap - GW'(1);
                  end
               end
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
